// File: rtl/uart_mmio_fifo_if.sv
// CPU data-bus bundle between the bus master and the UART MMIO front end.
interface uart_mmio_fifo_if;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        we_n;
    logic        oe_n;

    modport master (output addr, output din, output we_n, output oe_n, input dout);
    modport slave  (input addr, input din, input we_n, input oe_n, output dout);
endinterface

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART front end: RX/TX byte FIFOs, sticky error/status, irq enables
// and the four-state transmit handshake.
//   state   | meaning
//   S_IDLE  | waiting for a queued byte while the transmitter is free
//   S_START | one-cycle uart_start pulse with uart_tx loaded
//   S_ACK   | waiting for uart_busy to rise, bounded by the terminal-count timer
//   S_DONE  | waiting for uart_busy to fall
module uart_mmio_fifo #(
    parameter logic [31:0] DATA_ADDR = 32'hbfd003f8,
    parameter logic [31:0] STAT_ADDR = 32'hbfd003fc,
    parameter logic [31:0] CTRL_ADDR = 32'hbfd00400,
    parameter int unsigned RX_AW     = 4,
    parameter int unsigned TX_AW     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    uart_mmio_fifo_if.slave        bus,
    input  logic                   uart_ready,
    input  logic [7:0]             uart_rx,
    output logic                   uart_clear,
    input  logic                   uart_busy,
    output logic [7:0]             uart_tx,
    output logic                   uart_start,
    output logic                   irq
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_ACK, S_DONE} tx_state_e;

    localparam logic [RX_AW:0] RX_FULL = {1'b1, {RX_AW{1'b0}}};
    localparam logic [TX_AW:0] TX_FULL = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0] RX_ONE  = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [TX_AW:0] TX_ONE  = {{TX_AW{1'b0}}, 1'b1};
    // ACK lasts 15 cycles: load 14 and leave on terminal count 0
    localparam logic [3:0]     ACK_TC_LOAD = 4'd14;

    logic [7:0]     rx_mem_q [0:(1 << RX_AW) - 1];
    logic [7:0]     tx_mem_q [0:(1 << TX_AW) - 1];
    logic [RX_AW:0] rx_head_q, rx_rear_q, rx_cnt;
    logic [TX_AW:0] tx_head_q, tx_rear_q, tx_cnt;
    logic           rx_empty, rx_full, tx_empty, tx_full, tx_idle;
    logic           rd, wr, sel_data, sel_stat, sel_ctrl, stat_wr;
    logic           rx_pop, rx_push, rx_ovf_set, rx_udf_set, tx_push, tx_ovf_set, tx_pop;
    logic           rx_ovf_q, rx_ovf_d, rx_udf_q, rx_udf_d, tx_ovf_q, tx_ovf_d;
    logic           rx_ie_q, tx_ie_q, irq_q, irq_d;
    tx_state_e      state_q, state_d;
    logic [3:0]     ack_cnt_q, ack_cnt_d;
    logic [7:0]     uart_tx_q, uart_tx_d;
    logic [7:0]     rx_head_byte, tx_head_byte;
    logic           unused_din;

    assign unused_din   = ^bus.din[31:8];
    assign rx_cnt       = rx_rear_q - rx_head_q;
    assign tx_cnt       = tx_rear_q - tx_head_q;
    assign rx_empty     = (rx_cnt == '0);
    assign tx_empty     = (tx_cnt == '0);
    assign rx_full      = (rx_cnt == RX_FULL);
    assign tx_full      = (tx_cnt == TX_FULL);
    assign tx_idle      = tx_empty & (state_q == S_IDLE);
    assign rx_head_byte = rx_mem_q[rx_head_q[RX_AW-1:0]];
    assign tx_head_byte = tx_mem_q[tx_head_q[TX_AW-1:0]];

    assign rd       = ~bus.oe_n & bus.we_n;
    assign wr       = ~bus.we_n;
    assign sel_data = (bus.addr == DATA_ADDR);
    assign sel_stat = (bus.addr == STAT_ADDR);
    assign sel_ctrl = (bus.addr == CTRL_ADDR);
    assign stat_wr  = wr & sel_stat;

    // a pop frees the head slot in the same cycle, so a full RX still accepts the push
    assign rx_pop     = rd & sel_data & ~rx_empty;
    assign rx_udf_set = rd & sel_data & rx_empty;
    assign rx_push    = uart_ready & (~rx_full | rx_pop);
    assign rx_ovf_set = uart_ready & rx_full & ~rx_pop;
    assign tx_push    = wr & sel_data & ~tx_full;
    assign tx_ovf_set = wr & sel_data & tx_full;

    assign rx_ovf_d = (rx_ovf_q & ~(stat_wr & bus.din[3])) | rx_ovf_set;
    assign rx_udf_d = (rx_udf_q & ~(stat_wr & bus.din[4])) | rx_udf_set;
    assign tx_ovf_d = (tx_ovf_q & ~(stat_wr & bus.din[5])) | tx_ovf_set;
    assign irq_d    = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_idle) | rx_ovf_q | tx_ovf_q;

    assign uart_clear = uart_ready;
    assign uart_start = (state_q == S_START);
    assign uart_tx    = uart_tx_q;
    assign irq        = irq_q;

    always_comb begin
        bus.dout = '0;
        if (rd) begin
            if (sel_data) begin
                bus.dout = {24'h0, rx_empty ? 8'h00 : rx_head_byte};
            end else if (sel_stat) begin
                bus.dout = {8'h00, 8'(rx_cnt), 8'(tx_cnt), 2'b00, tx_ovf_q, rx_udf_q,
                            rx_ovf_q, tx_idle, ~rx_empty, ~tx_full};
            end else if (sel_ctrl) begin
                bus.dout = {30'h0, tx_ie_q, rx_ie_q};
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ack_cnt_d = ack_cnt_q;
        uart_tx_d = uart_tx_q;
        tx_pop    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tx_empty && !uart_busy) begin
                    tx_pop    = 1'b1;
                    uart_tx_d = tx_head_byte;
                    state_d   = S_START;
                end
            end
            S_START: begin
                ack_cnt_d = ACK_TC_LOAD;
                state_d   = S_ACK;
            end
            S_ACK: begin
                if (uart_busy) begin
                    state_d = S_DONE;
                end else if (ack_cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (!uart_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem_q[rx_rear_q[RX_AW-1:0]] <= uart_rx;
        end
        if (tx_push) begin
            tx_mem_q[tx_rear_q[TX_AW-1:0]] <= bus.din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_head_q <= '0;
            rx_rear_q <= '0;
            tx_head_q <= '0;
            tx_rear_q <= '0;
            rx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
            tx_ovf_q  <= 1'b0;
            rx_ie_q   <= 1'b0;
            tx_ie_q   <= 1'b0;
            irq_q     <= 1'b0;
            state_q   <= S_IDLE;
            ack_cnt_q <= '0;
            uart_tx_q <= '0;
        end else begin
            if (rx_pop)  rx_head_q <= rx_head_q + RX_ONE;
            if (rx_push) rx_rear_q <= rx_rear_q + RX_ONE;
            if (tx_pop)  tx_head_q <= tx_head_q + TX_ONE;
            if (tx_push) tx_rear_q <= tx_rear_q + TX_ONE;
            rx_ovf_q  <= rx_ovf_d;
            rx_udf_q  <= rx_udf_d;
            tx_ovf_q  <= tx_ovf_d;
            if (wr && sel_ctrl) begin
                tx_ie_q <= bus.din[1];
                rx_ie_q <= bus.din[0];
            end
            irq_q     <= irq_d;
            state_q   <= state_d;
            ack_cnt_q <= ack_cnt_d;
            uart_tx_q <= uart_tx_d;
        end
    end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Randomized and directed bench for uart_mmio_fifo against a queue-based behavioural model.
module tb_uart_mmio_fifo;
    localparam int RX_AW    = 2;
    localparam int TX_AW    = 1;
    localparam int RX_DEPTH = 1 << RX_AW;
    localparam int TX_DEPTH = 1 << TX_AW;
    localparam logic [31:0] DA = 32'hbfd003f8;
    localparam logic [31:0] SA = 32'hbfd003fc;
    localparam logic [31:0] CA = 32'hbfd00400;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_ready, uart_clear, uart_busy, uart_start, irq;
    logic [7:0] uart_rx, uart_tx;

    uart_mmio_fifo_if bus ();

    uart_mmio_fifo #(
        .DATA_ADDR(DA), .STAT_ADDR(SA), .CTRL_ADDR(CA), .RX_AW(RX_AW), .TX_AW(TX_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .uart_ready(uart_ready), .uart_rx(uart_rx), .uart_clear(uart_clear),
        .uart_busy(uart_busy), .uart_tx(uart_tx), .uart_start(uart_start), .irq(irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic busy_auto = 1'b0;
    logic busy_man  = 1'b0;
    int   bcnt = 0;
    logic [7:0] tx_seen[$];
    int         start_cyc[$];

    // model: FIFO contents as queues, transmitter as a phase number
    // phase 0 idle, 1 start pulse, 2 waiting for busy (m_ack cycles so far), 3 waiting for release
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    logic m_rx_ovf = 0, m_rx_udf = 0, m_tx_ovf = 0, m_rx_ie = 0, m_tx_ie = 0, m_irq = 0;
    int   m_phase = 0;
    int   m_ack = 0;
    logic [7:0] m_tx = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_dout();
        logic [31:0] r;
        r = '0;
        if (!bus.oe_n && bus.we_n) begin
            if (bus.addr == DA) begin
                r = (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'h0;
            end else if (bus.addr == SA) begin
                r = {8'h00, 8'(rx_q.size()), 8'(tx_q.size()), 2'b00, m_tx_ovf, m_rx_udf, m_rx_ovf,
                     (tx_q.size() == 0 && m_phase == 0), (rx_q.size() != 0), (tx_q.size() != TX_DEPTH)};
            end else if (bus.addr == CA) begin
                r = {30'h0, m_tx_ie, m_rx_ie};
            end
        end
        return r;
    endfunction

    task automatic model_step();
        int   rsz, tsz;
        logic rd, wr, pop, s_rovf, s_udf, s_tovf, irq_nx;
        if (!rst_n) begin
            rx_q.delete();
            tx_q.delete();
            m_rx_ovf = 0; m_rx_udf = 0; m_tx_ovf = 0; m_rx_ie = 0; m_tx_ie = 0; m_irq = 0;
            m_phase = 0; m_ack = 0; m_tx = 8'h00;
            return;
        end
        rsz = rx_q.size();
        tsz = tx_q.size();
        rd = !bus.oe_n && bus.we_n;
        wr = !bus.we_n;
        s_rovf = 0; s_udf = 0; s_tovf = 0;
        irq_nx = (m_rx_ie && rsz > 0) || (m_tx_ie && tsz == 0 && m_phase == 0) || m_rx_ovf || m_tx_ovf;

        pop = rd && bus.addr == DA && rsz > 0;
        if (rd && bus.addr == DA && rsz == 0) s_udf = 1;
        if (pop) void'(rx_q.pop_front());
        if (uart_ready) begin
            if (rsz < RX_DEPTH || pop) rx_q.push_back(uart_rx);
            else s_rovf = 1;
        end

        case (m_phase)
            0: if (tsz > 0 && !uart_busy) begin m_tx = tx_q.pop_front(); m_phase = 1; end
            1: begin m_phase = 2; m_ack = 0; end
            2: begin
                m_ack++;
                if (uart_busy) m_phase = 3;
                else if (m_ack == 15) m_phase = 0;
            end
            default: if (!uart_busy) m_phase = 0;
        endcase
        if (wr && bus.addr == DA) begin
            if (tsz == TX_DEPTH) s_tovf = 1;
            else tx_q.push_back(bus.din[7:0]);
        end

        if (wr && bus.addr == SA) begin
            if (bus.din[5]) m_tx_ovf = 0;
            if (bus.din[4]) m_rx_udf = 0;
            if (bus.din[3]) m_rx_ovf = 0;
        end
        if (s_tovf) m_tx_ovf = 1;
        if (s_udf)  m_rx_udf = 1;
        if (s_rovf) m_rx_ovf = 1;
        if (wr && bus.addr == CA) begin
            m_tx_ie = bus.din[1];
            m_rx_ie = bus.din[0];
        end
        m_irq = irq_nx;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        check("dout", bus.dout, model_dout());
        check("uart_start", {31'h0, uart_start}, {31'h0, m_phase == 1});
        check("uart_tx", {24'h0, uart_tx}, {24'h0, m_tx});
        check("uart_clear", {31'h0, uart_clear}, {31'h0, uart_ready});
        check("irq", {31'h0, irq}, {31'h0, m_irq});
    end

    // transmitter stand-in: busy for three cycles after each start pulse when in auto mode
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_start === 1'b1) begin
                tx_seen.push_back(uart_tx);
                start_cyc.push_back(cyc);
                bcnt = 3;
            end else if (bcnt > 0) begin
                bcnt--;
            end
            uart_busy = busy_auto ? (bcnt != 0) : busy_man;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.addr = a; bus.oe_n = 1'b0; bus.we_n = 1'b1;
        #2;
        d = bus.dout;
        tick();
        bus.oe_n = 1'b1; bus.addr = '0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        bus.addr = a; bus.din = v; bus.we_n = 1'b0;
        tick();
        bus.we_n = 1'b1; bus.addr = '0; bus.din = '0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        uart_ready = 1'b1; uart_rx = b;
        tick();
        uart_ready = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int i = 0; i < budget && tx_seen.size() < n; i++) tick();
        check("start_count", tx_seen.size(), n);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        bus.addr = '0; bus.din = '0; bus.we_n = 1'b1; bus.oe_n = 1'b1;
        uart_ready = 1'b0; uart_rx = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check("rst_dout", bus.dout, 32'h0);
        check("rst_uart_tx", {24'h0, uart_tx}, 32'h0);
        check("rst_uart_start", {31'h0, uart_start}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // RX fill and overflow
        for (int i = 0; i < 5; i++) rx_push(8'h11 + 8'(i));
        bus_read(SA, d);
        check("rx_fill_stat", d, 32'h0004000F);
        check("rx_ovf_irq", {31'h0, irq}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            bus_read(DA, d);
            check("rx_read", d, 32'h11 + i);
        end
        bus_read(DA, d);
        check("rx_underflow_read", d, 32'h0);
        bus_read(SA, d);
        check("rx_udf_stat", d, 32'h0000001D);
        bus_write(SA, 32'h38);
        bus_read(SA, d);
        check("err_clear_stat", d, 32'h00000005);
        check("irq_after_clear", {31'h0, irq}, 32'h0);

        // simultaneous push and pop on a full RX
        for (int i = 0; i < 4; i++) rx_push(8'hA0 + 8'(i));
        uart_ready = 1'b1; uart_rx = 8'hAA;
        bus_read(DA, d);
        uart_ready = 1'b0;
        check("full_pushpop_read", d, 32'hA0);
        bus_read(SA, d);
        check("full_pushpop_stat", d, 32'h00040007);
        for (int i = 0; i < 4; i++) begin
            bus_read(DA, d);
            check("full_pushpop_order", d, (i == 3) ? 32'hAA : 32'hA1 + i);
        end

        // TX ordering with the busy handshake
        busy_auto = 1'b1;
        tick();
        tx_seen.delete(); start_cyc.delete();
        bus_write(DA, 32'h41);
        bus_write(DA, 32'h42);
        bus_write(DA, 32'h43);
        wait_starts(3, 60);
        if (tx_seen.size() >= 3) begin
            check("tx_order0", {24'h0, tx_seen[0]}, 32'h41);
            check("tx_order1", {24'h0, tx_seen[1]}, 32'h42);
            check("tx_order2", {24'h0, tx_seen[2]}, 32'h43);
            check("tx_spacing01", start_cyc[1] - start_cyc[0], 32'd5);
            check("tx_spacing12", start_cyc[2] - start_cyc[1], 32'd5);
        end
        repeat (10) tick();

        // ACK timeout with busy held low
        busy_auto = 1'b0; busy_man = 1'b0;
        tick();
        tx_seen.delete(); start_cyc.delete();
        bus_write(DA, 32'h51);
        bus_write(DA, 32'h52);
        wait_starts(2, 60);
        if (tx_seen.size() >= 2) begin
            check("timeout_order0", {24'h0, tx_seen[0]}, 32'h51);
            check("timeout_order1", {24'h0, tx_seen[1]}, 32'h52);
            check("timeout_spacing", start_cyc[1] - start_cyc[0], 32'd17);
        end
        repeat (20) tick();
        bus_read(SA, d);
        check("timeout_idle_stat", d, 32'h00000005);

        // TX full with pointer wrap
        for (int r = 0; r < 3; r++) begin
            busy_auto = 1'b0; busy_man = 1'b1;
            repeat (2) tick();
            b = 8'h60 + 8'(3 * r);
            bus_write(DA, {24'h0, b});
            bus_write(DA, {24'h0, b + 8'd1});
            bus_write(DA, {24'h0, b + 8'd2});
            bus_read(SA, d);
            check("tx_full_stat", d, 32'h00000220);
            bus_write(SA, 32'h38);
            tx_seen.delete(); start_cyc.delete();
            busy_auto = 1'b1;
            wait_starts(2, 40);
            if (tx_seen.size() >= 2) begin
                check("tx_wrap_order0", {24'h0, tx_seen[0]}, {24'h0, b});
                check("tx_wrap_order1", {24'h0, tx_seen[1]}, {24'h0, b + 8'd1});
            end
            repeat (10) tick();
        end

        // async reset during START
        busy_auto = 1'b0; busy_man = 1'b0;
        tick();
        bus_write(CA, 32'h3);
        rx_push(8'h77);
        rx_push(8'h78);
        bus_read(CA, d);
        check("ctrl_read", d, 32'h3);
        check("irq_rx_ie", {31'h0, irq}, 32'h1);
        bus_write(DA, 32'h99);
        for (int i = 0; i < 10 && uart_start !== 1'b1; i++) tick();
        check("start_before_rst", {31'h0, uart_start}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_start", {31'h0, uart_start}, 32'h0);
        check("rst_async_irq", {31'h0, irq}, 32'h0);
        check("rst_async_dout", bus.dout, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        bus_read(SA, d);
        check("post_rst_stat", d, 32'h00000005);
        bus_read(CA, d);
        check("post_rst_ctrl", d, 32'h0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ((i / 500) % 3)
                0: busy_auto = 1'b1;
                1: begin busy_auto = 1'b0; busy_man = ($urandom_range(0, 7) == 0); end
                default: begin busy_auto = 1'b0; busy_man = $urandom_range(0, 1) != 0; end
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2, 3: bus.addr = DA;
                4, 5, 6:    bus.addr = SA;
                7, 8:       bus.addr = CA;
                default:    bus.addr = $urandom;
            endcase
            bus.we_n   = ($urandom_range(0, 3) != 0);
            bus.oe_n   = ($urandom_range(0, 1) != 0);
            bus.din    = $urandom;
            uart_ready = ($urandom_range(0, 9) < 3);
            uart_rx    = 8'($urandom);
            tick();
        end
        bus.we_n = 1'b1; bus.oe_n = 1'b1; bus.addr = '0; uart_ready = 1'b0;
        busy_auto = 1'b1;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
